// File: rtl/register_unit.sv
// General datapath register: multi-source load, in-place inc/dec/shift,
// and a small LIFO save/restore stack with a sticky error flag.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module register_unit #(
  parameter int n           = `DEFAULT_WIDTH,
  parameter int SOURCES     = 4,
  parameter int SEL_W       = (SOURCES > 1) ? $clog2(SOURCES) : 1,
  parameter int DEPTH       = 2,
  parameter logic [n-1:0] RESET_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           op,
  input  logic [SEL_W-1:0]     select,
  input  logic [SOURCES*n-1:0] in_bus,
  input  logic                 err_clear,
  output logic [n-1:0]         out,
  output logic                 carry,
  output logic                 zero,
  output logic                 stack_full,
  output logic                 stack_empty,
  output logic                 error
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_PUSH = 3'd6,
    OP_POP  = 3'd7
  } op_e;

  logic [n-1:0]  out_q, out_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic          err_set;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  stk_q [DEPTH];
  logic [n-1:0]  stk_d [DEPTH];

  logic [n-1:0]  ld_val;
  logic [n-1:0]  pop_val;
  logic          sel_bad;
  logic          full;
  logic          empty;
  logic [n:0]    inc_sum;
  logic [n:0]    dec_sum;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign sel_bad = ({1'b0, select} >= (SEL_W+1)'(SOURCES));
  assign inc_sum = {1'b0, out_q} + {{n{1'b0}}, 1'b1};
  assign dec_sum = {1'b0, out_q} - {{n{1'b0}}, 1'b1};

  always_comb begin
    ld_val = '0;
    for (int k = 0; k < SOURCES; k++) begin
      if ((SEL_W+1)'(k) == {1'b0, select}) ld_val = in_bus[k*n +: n];
    end
  end

  always_comb begin
    pop_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == cnt_q - CW'(1)) pop_val = stk_q[i];
    end
  end

  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    for (int i = 0; i < DEPTH; i++) stk_d[i] = stk_q[i];
    case (op_e'(op))
      OP_HOLD: ;
      OP_LOAD: begin
        if (sel_bad) begin
          err_set = 1'b1;
        end else begin
          out_d   = ld_val;
          carry_d = 1'b0;
        end
      end
      OP_INC: {carry_d, out_d} = inc_sum;
      OP_DEC: {carry_d, out_d} = dec_sum;
      OP_SHL: begin
        out_d   = {out_q[n-2:0], 1'b0};
        carry_d = out_q[n-1];
      end
      OP_SHR: begin
        out_d   = {1'b0, out_q[n-1:1]};
        carry_d = out_q[0];
      end
      OP_PUSH: begin
        if (full) begin
          err_set = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == cnt_q) stk_d[i] = out_q;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          err_set = 1'b1;
        end else begin
          out_d   = pop_val;
          carry_d = 1'b0;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // a new error on the same edge beats the clear
  always_comb begin
    err_d = err_q;
    if (err_clear) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q   <= RESET_VALUE;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= stk_d[i];
    end
  end

  assign out         = out_q;
  assign carry       = carry_q;
  assign zero        = (out_q == '0);
  assign stack_full  = full;
  assign stack_empty = empty;
  assign error       = err_q;

endmodule

// File: doc/register_unit.md
Name: register_unit

Overview:
- Parametrised successor to the 4-way load register: N-bit register, SOURCES-way input select, in-place arithmetic/shift ops, and a small save/restore stack.
- Used as the general datapath register in the VLE datapath: accumulator, address register, loop counter.
- Controlled by an op code per cycle; status flags are available to the controller FSM.

Parameters:
- n, `DEFAULT_WIDTH, register/data width in bits (n >= 2).
- SOURCES, 4, number of load inputs (2..16).
- SEL_W, $clog2(SOURCES), select width (derived, not overridden).
- DEPTH, 2, save-stack entries (1..8).
- RESET_VALUE, 0, value of out after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- op  in  3  operation code, sampled each rising edge.
- select  in  SEL_W  load source index for LOAD.
- in_bus  in  SOURCES*n  packed load sources; source k = in_bus[k*n +: n].
- err_clear  in  1  synchronous clear of the error flag.
- out  out  n  register value.
- carry  out  1  registered carry/borrow/shift-out flag.
- zero  out  1  combinational, (out == 0).
- stack_full  out  1  count == DEPTH.
- stack_empty  out  1  count == 0.
- error  out  1  sticky illegal-operation flag.

Behaviour:
- Reset (reset == 0, async):
  - out = RESET_VALUE; carry = 0; error = 0.
  - Stack count = 0; all stack entries = 0.
  - Mid-operation reset abandons the op in flight. First op is sampled on the first rising edge after release.
- All updates occur on the rising clock edge while reset == 1. Single-cycle latency: out/carry/flags reflect an op on the edge that samples it.
- Op codes:
  - 0 HOLD: no change.
  - 1 LOAD: out = source[select]; carry = 0.
    - If select >= SOURCES (only possible when SOURCES is not a power of 2): out unchanged, error = 1.
  - 2 INC: {carry, out} = out + 1. Wrap from all-ones to 0 sets carry = 1; otherwise carry = 0.
  - 3 DEC: out = out - 1; carry = borrow (1 only when out was 0, which gives all-ones).
  - 4 SHL: out = {out[n-2:0], 1'b0}; carry = old out[n-1].
  - 5 SHR: out = {1'b0, out[n-1:1]}; carry = old out[0].
  - 6 PUSH: stack[count] = out; count++. out and carry unchanged.
    - If stack_full: no write, count unchanged, error = 1.
  - 7 POP: out = stack[count-1]; count--; carry = 0.
    - If stack_empty: out unchanged, error = 1.
- Error flag:
  - Sticky once set.
  - err_clear = 1 clears it on the edge, unless the same edge sets a new error; set wins.
- Arithmetic: unsigned, modulo 2^n. No sign handling.
- Stack: LIFO. Entries above count keep stale data and are not observable. No simultaneous push/pop is possible, since op is one code.
- zero follows out combinationally. stack_full/stack_empty are decoded from the registered count, so they update together with out.

Test Plan (n=8, SOURCES=4, DEPTH=2):
- Reset/load: reset=0 -> out=0x00, carry=0, zero=1, stack_empty=1. Release, LOAD with select=2, source2=0xA5 -> out=0xA5, zero=0.
- Wrap/borrow:
  - LOAD 0xFF, INC -> out=0x00, carry=1, zero=1.
  - DEC -> out=0xFF, carry=1.
  - DEC -> out=0xFE, carry=0.
- Shifts:
  - LOAD 0x81, SHL -> out=0x02, carry=1.
  - SHR -> out=0x01, carry=0.
  - SHR -> out=0x00, carry=1.
- Stack:
  - LOAD 0x11, PUSH, LOAD 0x22, PUSH -> stack_full=1.
  - LOAD 0x33, PUSH -> error=1, out=0x33.
  - POP -> 0x22; POP -> 0x11, stack_empty=1.
  - POP -> error stays 1, out=0x11.
- Error clear: err_clear=1 with HOLD -> error=0. err_clear=1 with POP on empty stack -> error=1.
- Async reset mid-sequence: after two PUSHes and out=0x5A, drop reset between edges -> out=0, count=0, error=0 immediately, without waiting for a clock edge. Then POP -> error=1.
